// File: rtl/mby_tag_ring_sched.sv
// Tag ring slot scheduler: passes upstream ring traffic through with absolute
// priority and inserts local requester tags into empty slots in round-robin
// order. A requester that keeps losing to ring traffic eventually raises
// ring_hold so the upstream node leaves a slot free for it.
module mby_tag_ring_sched #(
    parameter int N_REQ        = 4,
    parameter int TAG_W        = 64,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_en,
    input  logic                     ring_in_vld,
    input  logic [TAG_W-1:0]         ring_in_data,
    output logic                     ring_out_vld,
    output logic [TAG_W-1:0]         ring_out_data,
    output logic                     ring_hold,
    input  logic [N_REQ-1:0]         req_vld,
    input  logic [N_REQ*TAG_W-1:0]   req_data,
    output logic [N_REQ-1:0]         req_rdy,
    output logic                     starve_state,
    output logic [31:0]              ins_cnt
);

    localparam int         IDX_W = $clog2(N_REQ);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic {RUN, HOLD} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   lastGrant_q;
    logic [7:0]         starveCnt_q;
    logic [7:0]         starveCnt_d;
    logic [31:0]        insCnt_q;
    logic               outVld_q;
    logic [TAG_W-1:0]   outData_q;
    logic               ringHold_q;
    logic               starveState_q;

    logic [TAG_W-1:0]   reqTag [N_REQ];
    logic               grantVld;
    logic [IDX_W-1:0]   grantIdx;
    logic [IDX_W-1:0]   cand;
    logic               xfer;
    logic               blocked;
    logic               starveClear;

    // Split the flat request bus into one tag per requester
    for (genvar i = 0; i < N_REQ; i++) begin : gTag
        assign reqTag[i] = req_data[i*TAG_W +: TAG_W];
    end

    // Round-robin search starting just after the last granted requester;
    // only an empty ring slot with insertion enabled and reset released can grant
    always_comb begin
        grantVld = 1'b0;
        grantIdx = lastGrant_q;
        cand     = '0;
        if (rst && cfg_en && !ring_in_vld) begin
            for (int k = 1; k <= N_REQ; k++) begin
                cand = IDX_W'((int'(lastGrant_q) + k) % N_REQ);
                if (!grantVld && req_vld[cand]) begin
                    grantVld = 1'b1;
                    grantIdx = cand;
                end
            end
        end
    end

    // One-hot accept toward the winning requester
    always_comb begin
        req_rdy = '0;
        if (grantVld) begin
            req_rdy[grantIdx] = 1'b1;
        end
    end

    assign xfer        = |(req_vld & req_rdy);
    assign blocked     = (|req_vld) && cfg_en && ring_in_vld;
    assign starveClear = xfer || !cfg_en || !(|req_vld);

    // Starvation count: climbs on blocked cycles, saturates, clears on relief
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (starveClear) begin
            starveCnt_d = '0;
        end else if (blocked && (starveCnt_q < LIMIT)) begin
            starveCnt_d = starveCnt_q + 8'd1;
        end
    end

    // Slot register, grant pointer, insertion counter and starvation count
    always_ff @(posedge clk) begin
        if (!rst) begin
            outVld_q    <= 1'b0;
            outData_q   <= '0;
            lastGrant_q <= IDX_W'(N_REQ - 1);
            insCnt_q    <= '0;
            starveCnt_q <= '0;
        end else begin
            starveCnt_q <= starveCnt_d;
            if (ring_in_vld) begin
                outVld_q  <= 1'b1;
                outData_q <= ring_in_data;
            end else if (xfer) begin
                outVld_q    <= 1'b1;
                outData_q   <= reqTag[grantIdx];
                lastGrant_q <= grantIdx;
                insCnt_q    <= insCnt_q + 32'd1;
            end else begin
                outVld_q <= 1'b0;
            end
        end
    end

    // RUN/HOLD state machine with registered hold indications
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RUN;
            ringHold_q    <= 1'b0;
            starveState_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (starveCnt_d == LIMIT) begin
                        state_q       <= HOLD;
                        ringHold_q    <= 1'b1;
                        starveState_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (starveClear) begin
                        state_q       <= RUN;
                        ringHold_q    <= 1'b0;
                        starveState_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= RUN;
                    ringHold_q    <= 1'b0;
                    starveState_q <= 1'b0;
                end
            endcase
        end
    end

    assign ring_out_vld  = outVld_q;
    assign ring_out_data = outData_q;
    assign ring_hold     = ringHold_q;
    assign starve_state  = starveState_q;
    assign ins_cnt       = insCnt_q;

endmodule

// File: tb/tb_mby_tag_ring_sched.sv
// Self-checking bench for mby_tag_ring_sched: directed scenarios with literal
// expectations followed by a long randomized run against a behavioural model.
module tb_mby_tag_ring_sched;

    localparam int N   = 4;
    localparam int W   = 64;
    localparam int LIM = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_en;
    logic               ring_in_vld;
    logic [W-1:0]       ring_in_data;
    logic               ring_out_vld;
    logic [W-1:0]       ring_out_data;
    logic               ring_hold;
    logic [N-1:0]       req_vld;
    logic [N*W-1:0]     req_data;
    logic [N-1:0]       req_rdy;
    logic               starve_state;
    logic [31:0]        ins_cnt;

    int nCompared   = 0;
    int nMismatched = 0;

    // Behavioural model: expected slot, pointer, blocked-run length, count
    int           mLast;
    int           mBlk;
    bit           mOutVld;
    logic [W-1:0] mOutData;
    logic [31:0]  mIns;
    int           mXfer;
    logic [N-1:0] sampledRdy;
    logic [W-1:0] reqTag [N];

    mby_tag_ring_sched #(.N_REQ(N), .TAG_W(W), .STARVE_LIMIT(LIM)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_en        (cfg_en),
        .ring_in_vld   (ring_in_vld),
        .ring_in_data  (ring_in_data),
        .ring_out_vld  (ring_out_vld),
        .ring_out_data (ring_out_data),
        .ring_hold     (ring_hold),
        .req_vld       (req_vld),
        .req_data      (req_data),
        .req_rdy       (req_rdy),
        .starve_state  (starve_state),
        .ins_cnt       (ins_cnt)
    );

    always #5 clk = ~clk;

    // Pack the per-requester tags onto the flat request bus
    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W] = reqTag[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Who should win this cycle: first valid requester in rotation after the last winner
    function automatic int pickGrant();
        int i;
        if (!rst || !cfg_en || ring_in_vld) return -1;
        for (int k = 1; k <= N; k++) begin
            i = (mLast + k) % N;
            if (req_vld[i]) return i;
        end
        return -1;
    endfunction

    // Advance the model across one posedge given the inputs and the winner
    task automatic updateModel(input int g);
        if (!rst) begin
            mOutVld  = 1'b0;
            mOutData = '0;
            mBlk     = 0;
            mIns     = '0;
            mLast    = N - 1;
        end else begin
            if (ring_in_vld) begin
                mOutVld  = 1'b1;
                mOutData = ring_in_data;
            end else if (g >= 0) begin
                mOutVld  = 1'b1;
                mOutData = reqTag[g];
                mIns     = mIns + 32'd1;
                mLast    = g;
            end else begin
                mOutVld = 1'b0;
            end
            if (g >= 0 || !cfg_en || req_vld == '0) mBlk = 0;
            else if (ring_in_vld && mBlk < LIM) mBlk = mBlk + 1;
        end
    endtask

    task automatic checkOutput();
        bit expHold;
        expHold = (mBlk == LIM);
        check("ring_out_vld", 64'(ring_out_vld), 64'(mOutVld));
        check("ring_out_data", ring_out_data, mOutData);
        check("ring_hold", 64'(ring_hold), 64'(expHold));
        check("starve_state", 64'(starve_state), 64'(expHold));
        check("ins_cnt", 64'(ins_cnt), 64'(mIns));
    endtask

    // Drive one cycle of inputs, check the accept vector, then the registered outputs
    task automatic applyStimulus(input bit r, input bit en, input bit rv,
                                 input logic [W-1:0] rd, input logic [N-1:0] rq);
        int g;
        logic [N-1:0] one;
        logic [N-1:0] expRdy;
        one = 1;
        @(negedge clk);
        rst          = r;
        cfg_en       = en;
        ring_in_vld  = rv;
        ring_in_data = rd;
        req_vld      = rq;
        #1;
        g = pickGrant();
        expRdy = (g >= 0) ? (one << g) : '0;
        sampledRdy = req_rdy;
        check("req_rdy", 64'(req_rdy), 64'(expRdy));
        @(posedge clk);
        updateModel(g);
        mXfer = g;
        #1;
        checkOutput();
    endtask

    initial begin
        logic [N-1:0] one;
        logic [N-1:0] rq;
        bit           busy;
        bit           r;
        bit           en;
        one = 1;
        for (int i = 0; i < N; i++) reqTag[i] = 64'h1000 + 64'(i);
        rst = 1'b0; cfg_en = 1'b1; ring_in_vld = 1'b0; ring_in_data = '0; req_vld = '0;
        mLast = N - 1; mBlk = 0; mOutVld = 1'b0; mOutData = '0; mIns = '0; mXfer = -1;

        // Reset, including requests present while reset is held
        applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 4'hF);
        check("rst_rdy", 64'(sampledRdy), 64'h0);
        check("rst_out_vld", 64'(ring_out_vld), 64'h0);
        check("rst_hold", 64'(ring_hold), 64'h0);
        check("rst_ins", 64'(ins_cnt), 64'h0);

        // Pass-through beats all requesters
        applyStimulus(1'b1, 1'b1, 1'b1, 64'hA5, 4'hF);
        check("pt_rdy", 64'(sampledRdy), 64'h0);
        check("pt_vld", 64'(ring_out_vld), 64'h1);
        check("pt_data", ring_out_data, 64'hA5);

        // Round-robin over an idle ring
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, '0, 4'hF);
            check("rr_grant", 64'(sampledRdy), 64'(one << (c % 4)));
            check("rr_data", ring_out_data, 64'h1000 + 64'(c % 4));
        end
        check("rr_ins", 64'(ins_cnt), 64'd8);

        // Starvation: 20 blocked cycles for requester 0, then relief
        for (int c = 1; c <= 20; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 64'(c), 4'b0001);
            check("st_hold", 64'(ring_hold), 64'(c >= 16));
        end
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 4'b0001);
        check("st_rdy", 64'(sampledRdy), 64'h1);
        check("st_release", 64'(ring_hold), 64'h0);
        check("st_state", 64'(starve_state), 64'h0);

        // Disabled insertion: nothing granted, no hold, pointer untouched
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, '0, 4'hF);
            check("dis_rdy", 64'(sampledRdy), 64'h0);
            check("dis_hold", 64'(ring_hold), 64'h0);
        end
        check("dis_vld", 64'(ring_out_vld), 64'h0);
        check("dis_ins", 64'(ins_cnt), 64'd9);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 4'hF);
        check("dis_next", 64'(sampledRdy), 64'h2);

        // Reset while in HOLD
        for (int c = 0; c < 16; c++) applyStimulus(1'b1, 1'b1, 1'b1, 64'(c), 4'b0001);
        check("rh_hold", 64'(ring_hold), 64'h1);
        applyStimulus(1'b0, 1'b1, 1'b1, 64'h77, 4'hF);
        check("rh_release", 64'(ring_hold), 64'h0);
        check("rh_ins", 64'(ins_cnt), 64'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 4'hF);
        check("rh_first", 64'(sampledRdy), 64'h1);

        // Counter wrap
        applyStimulus(1'b1, 1'b1, 1'b0, '0, '0);
        force dut.insCnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.insCnt_q;
        mIns = 32'hFFFF_FFFF;
        #1;
        check("wrap_pre", 64'(ins_cnt), 64'hFFFF_FFFF);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 4'b0100);
        check("wrap_post", 64'(ins_cnt), 64'h0);

        // Randomized traffic with busy/idle ring phases
        busy = 1'b0;
        rq   = '0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 48 == 0) busy = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < N; i++) begin
                if (!rq[i] && $urandom_range(0, 3) == 0) rq[i] = 1'b1;
                else if (rq[i] && $urandom_range(0, 39) == 0) rq[i] = 1'b0;
                if (!rq[i]) reqTag[i] = {$urandom, $urandom};
            end
            r  = ($urandom_range(0, 299) != 0);
            en = ($urandom_range(0, 24) != 0);
            applyStimulus(r, en, busy ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 2) == 0),
                          {$urandom, $urandom}, rq);
            if (mXfer >= 0) begin
                rq[mXfer]     = 1'b0;
                reqTag[mXfer] = {$urandom, $urandom};
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
